// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder.
//   state_t   : controller states (IDLE / RUN / DONE), 2-bit encoding.
//   cnt_width : width of the chunk counter, clog2(nchunk) with a floor of 1 bit.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple of CHUNK full-adder cells.
// Ports:
//   a_c, b_c  : CHUNK-bit operand slices
//   c_in      : carry into bit 0
//   s_c       : CHUNK-bit sum slice
//   c_out     : carry out of the top bit
//   c_msb_in  : carry into the top bit (XOR with c_out gives signed overflow)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             c_in,
  output logic [CHUNK-1:0] s_c,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s_c  = '0;
    c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      s_c[i]   = a_c[i] ^ b_c[i] ^ c[i];
      c[i+1]   = (a_c[i] & b_c[i]) | (c[i] & (a_c[i] ^ b_c[i]));
    end
  end

  assign c_out    = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, carry held
// in a register between chunks, valid/ready handshake on both sides.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub      : operands; sub=1 computes a-b (cin ignored)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout, ovf      : result mod 2^WIDTH, carry-out (1 = no borrow on
//                         subtract), two's-complement overflow
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand set; in_ready=1
// RUN   | one chunk per edge, counter selects the slice
// DONE  | result held, out_valid=1 until out_ready
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] s_sl;
  logic             c_out;
  logic             c_msb;

  assign in_ready = (state == IDLE);

  assign a_sl = op_a[cnt*CHUNK +: CHUNK];
  assign b_sl = op_b[cnt*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_c      (a_sl),
    .b_c      (b_sl),
    .c_in     (carry),
    .s_c      (s_sl),
    .c_out    (c_out),
    .c_msb_in (c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            // Subtract as a + ~b + 1: invert B here, seed carry with 1.
            op_b  <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[cnt*CHUNK +: CHUNK] <= s_sl;
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout      <= c_out;
            ovf       <= c_msb ^ c_out;
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
module tb_chunked_serial_adder;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rand_rdy = 0;
  bit   ov_prev  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t e;
    int ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r    = ux - uy;
      sr   = sx - sy;
      e.co = (ux >= uy);
    end else begin
      r    = ux + uy + int'(c);
      sr   = sx + sy + int'(c);
      e.co = (r > 65535);
    end
    e.ov  = (sr > 32767) || (sr < -32768);
    e.s   = r[W-1:0];
    e.acc = 0;
    return e;
  endfunction

  // Monitor: latency on out_valid rise, value check on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
        else check("latency", 32'(cyc - q[0].acc), 32'(LAT));
      end
      ov_prev = out_valid;
      if (out_valid && out_ready && q.size() != 0) begin
        check("sum",  32'(sum),  32'(q[0].s));
        check("cout", 32'(cout), 32'(q[0].co));
        check("ovf",  32'(ovf),  32'(q[0].ov));
        void'(q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    exp_t e;
    int n = 0;
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e     = model(ia, ib, icin, isub);
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin : main
    exp_t ex;
    int n;
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Reset with in_valid asserted.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    repeat (6) @(negedge clk);
    check("no_accept_in_reset", 32'(out_valid), 32'd0);

    // Directed operations.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    drain();

    // Backpressure.
    @(posedge clk); #2; out_ready = 1'b0;
    issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    ex = q[0];
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_out_valid_seen", 32'(out_valid), 32'd1);
    a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum",       32'(sum),       32'(ex.s));
      check("bp_cout",      32'(cout),      32'(ex.co));
      check("bp_ovf",       32'(ovf),       32'(ex.ov));
    end
    @(posedge clk); #2; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready",  32'(in_ready),  32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    ex     = model(16'h0100, 16'h0200, 1'b0, 1'b0);
    ex.acc = cyc;
    q.push_back(ex);
    in_valid = 1'b0;
    drain();

    // Reset during RUN.
    issue(16'h3333, 16'h4444, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(negedge clk);
    check("midrst_no_result", 32'(out_valid), 32'd0);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();

    // Random operations with a randomly stalling consumer.
    rand_rdy = 1;
    for (int i = 0; i < 40; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    drain();
    rand_rdy = 0;
    @(posedge clk); #2; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
